spiker_result_fifo: RTL

- Parametrised successor to the single-stage spike-result writer between the spiker core and the spiker_adapter register file.
- Captures each sampled spike vector from the core into a DEPTH-entry frame FIFO, so software can fall several inference steps behind without losing results.
- Exposes the oldest frame as N_REG zero-padded WIDTH-bit words, plus occupancy and loss reporting.
- Full-FIFO policy is selectable at run time: drop the new frame, or overwrite the oldest.

---
 rtl/spiker_result_fifo_if.sv | 32 +++
 rtl/spiker_result_fifo.sv | 119 +++++++++++
 2 files changed

// File: rtl/spiker_result_fifo_if.sv
// Bundle between the spiker core / register-file decode (master) and the result FIFO (slave).
interface spiker_result_fifo_if #(
    parameter int WIDTH      = 32,
    parameter int DATA_WIDTH = 800,
    parameter int DEPTH      = 4,
    parameter int CNT_W      = 16
);
    localparam int N_REG   = (DATA_WIDTH + WIDTH - 1) / WIDTH;
    localparam int LEVEL_W = $clog2(DEPTH + 1);

    logic [DATA_WIDTH-1:0]  data_out_i;
    logic                   sample_i;
    logic                   pop_i;
    logic                   mode_i;
    logic                   clr_i;
    logic                   writer_ready_o;
    logic [N_REG*WIDTH-1:0] result_o;
    logic                   valid_o;
    logic [LEVEL_W-1:0]     level_o;
    logic                   overflow_o;
    logic [CNT_W-1:0]       lost_cnt_o;

    modport master (
        output data_out_i, sample_i, pop_i, mode_i, clr_i,
        input  writer_ready_o, result_o, valid_o, level_o, overflow_o, lost_cnt_o
    );

    modport slave (
        input  data_out_i, sample_i, pop_i, mode_i, clr_i,
        output writer_ready_o, result_o, valid_o, level_o, overflow_o, lost_cnt_o
    );
endinterface

// File: rtl/spiker_result_fifo.sv
// Frame FIFO holding spike vectors from the spiker core until software reads them out
// as zero-padded register words; full policy is drop-new or overwrite-oldest.
module spiker_result_fifo #(
    parameter int WIDTH      = 32,
    parameter int DATA_WIDTH = 800,
    parameter int DEPTH      = 4,
    parameter int CNT_W      = 16
) (
    input  logic               clk_i,
    input  logic               rst_i,
    spiker_result_fifo_if.slave bus
);
    localparam int N_REG   = (DATA_WIDTH + WIDTH - 1) / WIDTH;
    localparam int LEVEL_W = $clog2(DEPTH + 1);
    localparam int PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [LEVEL_W-1:0] FULL_LEVEL = LEVEL_W'(DEPTH);
    localparam logic [PTR_W-1:0]   LAST_PTR   = PTR_W'(DEPTH - 1);

    logic [DATA_WIDTH-1:0] storage [DEPTH];

    logic [PTR_W-1:0]   rd_ptr, wr_ptr, rd_ptr_next, wr_ptr_next;
    logic [LEVEL_W-1:0] level, level_next;
    logic               writer_ready, overflow;
    logic [CNT_W-1:0]   lost_cnt;
    logic               not_empty, full, do_pop, do_write, lost;
    logic [N_REG*WIDTH-1:0] padded;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    // A pop is only honoured on a non-empty FIFO; a concurrent pop frees a slot so a
    // push into a full FIFO is then a normal write rather than a loss.
    always_comb begin
        not_empty   = (level != '0);
        full        = (level == FULL_LEVEL);
        do_pop      = bus.pop_i && not_empty;
        do_write    = 1'b0;
        lost        = 1'b0;
        rd_ptr_next = rd_ptr;
        wr_ptr_next = wr_ptr;
        level_next  = level;

        if (do_pop) begin
            rd_ptr_next = ptr_inc(rd_ptr);
        end

        if (bus.sample_i) begin
            if (!full || do_pop) begin
                do_write    = 1'b1;
                wr_ptr_next = ptr_inc(wr_ptr);
                if (!do_pop) begin
                    level_next = level + 1'b1;
                end
            end else if (bus.mode_i) begin
                do_write    = 1'b1;
                wr_ptr_next = ptr_inc(wr_ptr);
                rd_ptr_next = ptr_inc(rd_ptr);
                lost        = 1'b1;
            end else begin
                lost = 1'b1;
            end
        end else if (do_pop) begin
            level_next = level - 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_ptr       <= '0;
            wr_ptr       <= '0;
            level        <= '0;
            writer_ready <= 1'b1;
        end else begin
            rd_ptr       <= rd_ptr_next;
            wr_ptr       <= wr_ptr_next;
            level        <= level_next;
            writer_ready <= (level_next != FULL_LEVEL) || bus.mode_i;
        end
    end

    // A loss coinciding with a clear restarts the count at one instead of zero.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            overflow <= 1'b0;
            lost_cnt <= '0;
        end else if (lost) begin
            overflow <= 1'b1;
            if (bus.clr_i) begin
                lost_cnt <= CNT_W'(1);
            end else if (!(&lost_cnt)) begin
                lost_cnt <= lost_cnt + 1'b1;
            end
        end else if (bus.clr_i) begin
            overflow <= 1'b0;
            lost_cnt <= '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_write) begin
            storage[wr_ptr] <= bus.data_out_i;
        end
    end

    always_comb begin
        padded = '0;
        if (not_empty) begin
            padded[DATA_WIDTH-1:0] = storage[rd_ptr];
        end
    end

    assign bus.result_o       = padded;
    assign bus.valid_o        = not_empty;
    assign bus.level_o        = level;
    assign bus.writer_ready_o = writer_ready;
    assign bus.overflow_o     = overflow;
    assign bus.lost_cnt_o     = lost_cnt;
endmodule
